// File: rtl/csa_accumulator.sv
// rtl/csa_accumulator.sv - carry-save multi-operand accumulator with chunked carry-propagate resolve
module csa_accumulator #(
    parameter int N     = 8,
    parameter int ACC_W = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    localparam int K     = ACC_W / CHUNK;
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   sum_reg;
    logic [ACC_W-1:0]   carry_reg;
    logic [ACC_W-1:0]   result;
    logic [IDX_W-1:0]   idx;
    logic               rc;
    logic               ovf;

    logic [ACC_W-1:0]   x;
    logic [ACC_W-1:0]   s;
    logic [ACC_W-1:0]   m;
    logic [CHUNK:0]     part;

    // One row of full adders per operand, plus one ripple chunk per resolve cycle.
    always_comb begin
        x    = ACC_W'(in_data);
        s    = x ^ sum_reg ^ carry_reg;
        m    = (x & sum_reg) | (x & carry_reg) | (sum_reg & carry_reg);
        part = {1'b0, sum_reg[idx*CHUNK +: CHUNK]}
             + {1'b0, carry_reg[idx*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, rc};
    end

    assign in_ready = (state == ACCUM);
    assign busy     = (state != ACCUM);
    assign out_data = result;
    assign out_ovf  = ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            sum_reg   <= '0;
            carry_reg <= '0;
            result    <= '0;
            idx       <= '0;
            rc        <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        sum_reg   <= s;
                        carry_reg <= {m[ACC_W-2:0], 1'b0};
                        // A carry shifted out of the top is a real 2^ACC_W contribution.
                        if (m[ACC_W-1]) begin
                            ovf <= 1'b1;
                        end
                        if (in_last) begin
                            state <= RESOLVE;
                            idx   <= '0;
                            rc    <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    result[idx*CHUNK +: CHUNK] <= part[CHUNK-1:0];
                    rc                         <= part[CHUNK];
                    if (idx == IDX_W'(K - 1)) begin
                        if (part[CHUNK]) begin
                            ovf <= 1'b1;
                        end
                        state     <= OUTPUT;
                        out_valid <= 1'b1;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        sum_reg   <= '0;
                        carry_reg <= '0;
                        ovf       <= 1'b0;
                        state     <= ACCUM;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accumulator.sv
// tb/tb_csa_accumulator.sv - self-checking bench for csa_accumulator
module tb_csa_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    csa_accumulator #(.N(8), .ACC_W(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               n;
        logic [3:0][7:0]  ops;
        logic [15:0]      exp_data;
        logic             exp_ovf;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Called just after a negedge; returns just after the negedge following the accepting edge.
    task automatic send_beat(input logic [7:0] d, input logic last);
        int n = 0;
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
    endtask

    task automatic send_packet(input logic [7:0] ops[$]);
        foreach (ops[i]) send_beat(ops[i], (i == ops.size() - 1));
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get_result(input string nm, input logic [15:0] ed, input logic eo);
        int n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_valid"}, 32'(out_valid), 1);
        chk({nm, "_data"}, 32'(out_data), 32'(ed));
        chk({nm, "_ovf"}, 32'(out_ovf), 32'(eo));
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t        vecs[5];
        logic [7:0]  q[$];
        int          total;
        int          cnt;
        int          seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{3, {8'h00, 8'h07, 8'h05, 8'h03}, 16'h000F, 1'b0};
        vecs[1] = '{1, {8'h00, 8'h00, 8'h00, 8'hAB}, 16'h00AB, 1'b0};
        vecs[2] = '{3, {8'h00, 8'h00, 8'h00, 8'h00}, 16'h0000, 1'b0};
        vecs[3] = '{4, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 16'h03FC, 1'b0};
        vecs[4] = '{4, {8'h7F, 8'h00, 8'h01, 8'h80}, 16'h0100, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_ovf", 32'(out_ovf), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);

        // Table-driven packets
        for (int v = 0; v < 5; v++) begin
            q = {};
            for (int j = 0; j < vecs[v].n; j++) q.push_back(vecs[v].ops[j]);
            send_packet(q);
            get_result($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_ovf);
        end

        // Latency: out_valid at the 4th edge after the in_last accept, one cycle wide
        out_ready = 1'b1;
        send_beat(8'd3, 1'b0);
        send_beat(8'd5, 1'b0);
        send_beat(8'd7, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk("lat_early", 32'(out_valid), 0);
        @(negedge clk);
        chk("lat_valid", 32'(out_valid), 1);
        chk("lat_data", 32'(out_data), 32'h000F);
        chk("lat_ovf", 32'(out_ovf), 0);
        @(negedge clk);
        chk("lat_one_cycle", 32'(out_valid), 0);
        out_ready = 1'b0;

        // Single beat: busy for 4 resolve cycles plus 1 output cycle
        out_ready = 1'b1;
        send_beat(8'hAB, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        cnt  = 0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (!busy) break;
            cnt++;
            if (out_valid) begin
                seen = 1;
                chk("single_data", 32'(out_data), 32'h00AB);
            end
            @(negedge clk);
        end
        chk("single_busy_cycles", cnt, 5);
        chk("single_seen", seen, 1);
        out_ready = 1'b0;

        // 257 x 0xFF fills exactly 0xFFFF; one more unit overflows
        q = {};
        for (int j = 0; j < 257; j++) q.push_back(8'hFF);
        send_packet(q);
        get_result("ff257", 16'hFFFF, 1'b0);
        q.push_back(8'h01);
        send_packet(q);
        get_result("ff257p1", 16'h0000, 1'b1);

        // Backpressure with ignored in_valid pulses
        q = {8'h12, 8'h34};
        send_packet(q);
        for (int c = 0; c < 20 && !out_valid; c++) @(negedge clk);
        for (int c = 0; c < 6; c++) begin
            in_valid = c[0];
            in_data  = 8'h55;
            in_last  = 1'b1;
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_data", 32'(out_data), 32'h0046);
            chk("bp_ovf", 32'(out_ovf), 0);
            chk("bp_in_ready", 32'(in_ready), 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_released", 32'(out_valid), 0);
        chk("bp_in_ready_after", 32'(in_ready), 1);
        q = {8'd3};
        send_packet(q);
        get_result("bp_next", 16'd3, 1'b0);

        // Back-to-back packets with in_valid held high
        send_beat(8'd10, 1'b0);
        send_beat(8'd20, 1'b1);
        in_data = 8'd1;
        in_last = 1'b1;
        get_result("b2b_first", 16'd30, 1'b0);
        chk("b2b_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        get_result("b2b_second", 16'd1, 1'b0);

        // Async reset during the second resolve cycle discards the packet
        send_beat(8'hFF, 1'b0);
        send_beat(8'hFF, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_out_data", 32'(out_data), 0);
        chk("mid_rst_out_ovf", 32'(out_ovf), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) seen = 1;
            @(negedge clk);
        end
        chk("mid_rst_no_output", seen, 0);
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        q = {8'd2};
        send_packet(q);
        get_result("post_rst", 16'd2, 1'b0);

        // Randomized packets against an integer-sum reference
        for (int p = 0; p < 12; p++) begin
            int len;
            len   = $urandom_range(1, 300);
            q     = {};
            total = 0;
            for (int j = 0; j < len; j++) begin
                logic [7:0] d;
                d = 8'($urandom);
                if ($urandom_range(0, 7) == 0) d = 8'h00;
                q.push_back(d);
                total += int'(d);
            end
            send_packet(q);
            get_result($sformatf("rand%0d", p), total[15:0], (total >= 65536));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csa_accumulator.md
Name: csa_accumulator

Overview:
- Sequential multi-operand accumulator that stages operands in carry-save form.
- Each accepted operand goes through one row of full-adder cells: operand, sum vector and carry vector form the a, b, c bit-vectors; the bitwise sum and carry-out form the next state.
- Sits directly upstream of the final product output path of the multiplier library, and is used to sum partial products or product streams.
- At the end of a packet, a chunked carry-propagate pass resolves the carry-save pair into a binary result, and the result is offered on a valid/ready output.

Parameters:
- N, 8, operand width in bits.
- ACC_W, 16, accumulator and result width; ACC_W >= N.
- CHUNK, 4, bits resolved per cycle during carry propagation; ACC_W % CHUNK == 0. K = ACC_W/CHUNK.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  operand accepted when in_valid & in_ready at a rising edge.
- in_data  input  N  unsigned operand, zero-extended to ACC_W.
- in_last  input  1  qualifies the accepted beat as the final operand of a packet.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumed when out_valid & out_ready at a rising edge.
- out_data  output  ACC_W  packet sum mod 2^ACC_W.
- out_ovf  output  1  true packet sum >= 2^ACC_W.
- busy  output  1  high in RESOLVE or OUTPUT.

Behaviour:
- Reset (async, any state):
  - state=ACCUM; sum_reg, carry_reg, result, chunk index, internal carry and ovf all cleared.
  - out_valid=0, out_data=0, out_ovf=0, busy=0. in_ready=1 once reset deasserts.
- in_ready = (state==ACCUM), combinational from state only, with no dependence on in_valid. busy = !(state==ACCUM).
- ACCUM, on accept:
  - s = x ^ sum_reg ^ carry_reg, and m = maj(x, sum_reg, carry_reg), per bit, where x = zero-extended in_data.
  - sum_reg <= s. carry_reg <= {m[ACC_W-2:0], 1'b0}.
  - m[ACC_W-1]=1 sets the sticky ovf.
  - in_last=1 moves to RESOLVE with chunk index 0 and internal carry 0. Otherwise stay in ACCUM.
- RESOLVE:
  - Each cycle, chunk i: {c, result[i*CHUNK +: CHUNK]} <= sum_reg chunk + carry_reg chunk + c.
  - i increments each cycle. After chunk K-1 is written, a final c=1 sets ovf and the state moves to OUTPUT.
  - Exactly K cycles.
- Latency: out_valid rises at the K-th rising edge after the edge that accepted the in_last beat.
- OUTPUT:
  - out_valid=1. out_data=result and out_ovf=ovf, held stable until the handshake.
  - On out_valid & out_ready: clear sum_reg, carry_reg and ovf; state=ACCUM; out_valid=0.
  - out_data/out_ovf may retain their values after the handshake, but are only meaningful while out_valid=1.
  - in_ready=1 in the cycle after the handshake.
- Arithmetic invariant: sum_reg + carry_reg + 2^ACC_W·(dropped carries) equals the exact running total, so out_ovf is exact, not conservative.
- Boundaries:
  - Single-beat packet (first beat has in_last): result = operand, with the same K-cycle latency.
  - in_valid is ignored in RESOLVE/OUTPUT; no data is dropped, because in_ready=0 there.
  - out_ready high before out_valid has no effect.
  - Operand 0 beats are legal and leave the total unchanged.
  - in_last without in_valid is ignored.
  - rst mid-RESOLVE or mid-OUTPUT discards the packet; no out_valid is produced for it.
- No combinational path from in_* to out_*.

Test Plan:
- Beats 3, 5, 7 (last on 7), out_ready=1 (N=8, ACC_W=16, CHUNK=4) -> out_data=0x000F, out_ovf=0. out_valid rises exactly 4 edges after the accepting edge and lasts 1 cycle.
- Single beat 0xAB with in_last -> out_data=0x00AB, out_ovf=0. busy=1 for 5 cycles (4 RESOLVE + 1 OUTPUT).
- 257 beats of 0xFF, last on the 257th -> out_data=0xFFFF, out_ovf=0. Repeat with an extra beat 0x01 as last -> out_data=0x0000, out_ovf=1.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid -> out_valid, out_data and out_ovf stable. in_ready=0 throughout, and in_valid pulses are ignored. Release -> one handshake, in_ready=1 next cycle.
- Back-to-back packets {10,20 last} then {1 last} with in_valid held high -> outputs 30 then 1. No carry-over between packets.
- Assert rst during the 2nd RESOLVE cycle of packet {0xFF,0xFF last} -> all outputs 0 immediately (async). After release, packet {2 last} -> out_data=2, out_ovf=0.
